// File: rtl/enigma_key_sequencer_pkg.sv
// Shared types and constants for the Enigma key sequencer: FSM encoding,
// rotor position packing and modulo-26 position helpers.
package enigma_key_sequencer_pkg;

    localparam int ALPHA_LEN = 26;
    localparam int POS_W     = 5;
    localparam int CFG_W     = 3 * POS_W;

    // Bit offsets of each rotor field inside cfg_pos / dp_pos.
    localparam int R1_LSB = 10;  // fast rotor
    localparam int R2_LSB = 5;   // middle rotor
    localparam int R3_LSB = 0;   // slow rotor

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t LAST_POS  = pos_t'(ALPHA_LEN - 1);
    localparam pos_t ALPHA_POS = pos_t'(ALPHA_LEN);

    // Field order matches the bus packing: r1 in [14:10], r2 in [9:5], r3 in [4:0].
    typedef struct packed {
        pos_t r1;
        pos_t r2;
        pos_t r3;
    } rotor_pos_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Advance one position, wrapping 25 -> 0.
    function automatic pos_t pos_inc(input pos_t p);
        return (p >= LAST_POS) ? '0 : p + pos_t'(1);
    endfunction

    // Fold an out-of-range 5-bit value (26..31) back into 0..25 so the
    // position registers never hold an illegal letter.
    function automatic pos_t pos_norm(input pos_t p);
        return (p >= ALPHA_POS) ? p - ALPHA_POS : p;
    endfunction

endpackage

// File: rtl/enigma_key_sequencer_if.sv
// Bundle of configuration, plaintext, datapath and ciphertext signals
// between the key sequencer (slave) and its environment (master).
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both 1. The source holds valid and its payload stable until
// that edge; ready may change freely. dp_start/dp_done are single-cycle
// strobes without backpressure.
interface enigma_key_sequencer_if;
    import enigma_key_sequencer_pkg::*;

    logic             cfg_load;
    logic [CFG_W-1:0] cfg_pos;

    logic             in_valid;
    logic             in_ready;
    logic [POS_W-1:0] in_char;

    logic             dp_start;
    logic [POS_W-1:0] dp_char;
    logic [CFG_W-1:0] dp_pos;
    logic             dp_done;
    logic [POS_W-1:0] dp_result;

    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_char;

    logic             err;
    state_t           dbg_state;

    modport master (
        output cfg_load, cfg_pos,
        output in_valid, in_char,
        input  in_ready,
        input  dp_start, dp_char, dp_pos,
        output dp_done, dp_result,
        input  out_valid, out_char,
        output out_ready,
        input  err, dbg_state
    );

    modport slave (
        input  cfg_load, cfg_pos,
        input  in_valid, in_char,
        output in_ready,
        output dp_start, dp_char, dp_pos,
        input  dp_done, dp_result,
        output out_valid, out_char,
        input  out_ready,
        output err, dbg_state
    );

endinterface

// File: rtl/enigma_step_logic.sv
// Combinational rotor stepping: computes the next rotor positions for one
// key press, including the middle-rotor double-step anomaly.
module enigma_step_logic
    import enigma_key_sequencer_pkg::*;
#(
    parameter int NOTCH1 = 16,
    parameter int NOTCH2 = 4
) (
    input  rotor_pos_t cur,
    output rotor_pos_t nxt
);

    localparam pos_t N1 = pos_t'(NOTCH1);
    localparam pos_t N2 = pos_t'(NOTCH2);

    logic r1_at_notch;
    logic r2_at_notch;

    assign r1_at_notch = (cur.r1 == N1);
    assign r2_at_notch = (cur.r2 == N2);

    // Fast rotor always steps; the middle rotor steps when carried by the fast
    // rotor or when it sits on its own notch (double-step); the slow rotor is
    // carried by the middle notch. All decisions use the pre-step positions.
    always_comb begin
        nxt    = cur;
        nxt.r1 = pos_inc(cur.r1);
        if (r1_at_notch || r2_at_notch) begin
            nxt.r2 = pos_inc(cur.r2);
        end
        if (r2_at_notch) begin
            nxt.r3 = pos_inc(cur.r3);
        end
    end

endmodule

// File: rtl/enigma_key_sequencer.sv
// Enigma key sequencer: accepts one plaintext letter at a time, steps the
// rotors, launches the external rotor/reflector datapath, waits for its
// result (with timeout) and hands the ciphertext letter downstream.
module enigma_key_sequencer
    import enigma_key_sequencer_pkg::*;
#(
    parameter int NOTCH1  = 16,
    parameter int NOTCH2  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    enigma_key_sequencer_if.slave bus
);

    // Counter runs 0..TIMEOUT-1 across the WAIT cycles.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    rotor_pos_t      pos;
    rotor_pos_t      pos_step;
    rotor_pos_t      cfg_in;
    rotor_pos_t      cfg_norm;
    pos_t            dp_char_r;
    pos_t            out_char_r;
    logic [TO_W-1:0] to_cnt;
    logic            err_r;
    logic            char_legal;
    logic            timeout_hit;
    logic            in_ready_c;
    logic            dp_start_c;
    logic            out_valid_c;

    assign char_legal  = (bus.in_char <= LAST_POS);
    assign timeout_hit = (to_cnt == TO_LAST);

    assign cfg_in      = rotor_pos_t'(bus.cfg_pos);
    assign cfg_norm.r1 = pos_norm(cfg_in.r1);
    assign cfg_norm.r2 = pos_norm(cfg_in.r2);
    assign cfg_norm.r3 = pos_norm(cfg_in.r3);

    enigma_step_logic #(
        .NOTCH1(NOTCH1),
        .NOTCH2(NOTCH2)
    ) u_step (
        .cur(pos),
        .nxt(pos_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; cfg_load in IDLE blocks character acceptance.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!bus.cfg_load && bus.in_valid && char_legal) begin
                    state_nx = ST_STEP;
                end
            end
            ST_STEP:   state_nx = ST_LAUNCH;
            ST_LAUNCH: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (bus.dp_done) begin
                    state_nx = ST_OUT;
                end else if (timeout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Moore-style handshake outputs, all forced low while reset is held.
    always_comb begin
        in_ready_c  = 1'b0;
        dp_start_c  = 1'b0;
        out_valid_c = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:   in_ready_c  = !bus.cfg_load;
                ST_LAUNCH: dp_start_c  = 1'b1;
                ST_OUT:    out_valid_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Position, letter, timeout and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos        <= '0;
            dp_char_r  <= '0;
            out_char_r <= '0;
            to_cnt     <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_load) begin
                        pos <= cfg_norm;
                    end else if (bus.in_valid) begin
                        if (char_legal) begin
                            dp_char_r <= bus.in_char;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    pos <= pos_step;
                end
                ST_LAUNCH: begin
                    to_cnt <= '0;
                end
                ST_WAIT: begin
                    if (bus.dp_done) begin
                        out_char_r <= bus.dp_result;
                    end else if (timeout_hit) begin
                        err_r <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.dp_start  = dp_start_c;
    assign bus.out_valid = out_valid_c;
    assign bus.dp_pos    = pos;
    assign bus.dp_char   = dp_char_r;
    assign bus.out_char  = out_char_r;
    assign bus.err       = err_r & ~rst;
    assign bus.dbg_state = state;

endmodule
